demux_4_bit: RTL

DEMUX_4_BIT -- requirements
Module: Demux_4_Bit

---
 rtl/demux_4_bit_pkg.sv | 17 +
 rtl/demux_4_bit_slot.sv | 52 +++++
 rtl/demux_4_bit.sv | 94 +++++++++
 3 files changed

// File: rtl/demux_4_bit_pkg.sv
// Shared constants and helpers for the 4-way valid/ready demultiplexer.
package demux_4_bit_pkg;

  // Number of destinations and the selector width that addresses them
  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;

  // Drop counter width and its saturation value
  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Increment that sticks at CNT_MAX instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/demux_4_bit_slot.sv
// One-entry destination slot: holds a single word until the consumer takes it.
// A load and a drain in the same cycle replace the word with no bubble.
module demux_4_bit_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  can_accept_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  drain;

  // Consumer takes the word when it is presented and ready is high
  assign drain = valid_q & ready_i;

  // Room for a new word if empty, or if the current word leaves this cycle
  assign can_accept_o = ~valid_q | ready_i;

  // Next-state: a load wins over a drain; otherwise the drain empties the slot
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Slot state; reset discards any held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_4_bit.sv
// 4-way valid/ready demultiplexer: routes each accepted word into the one-entry
// slot chosen by selector; counts (saturating) cycles where input was refused.
module demux_4_bit
  import demux_4_bit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_Data,
  input  logic [SEL_W-1:0]      selector,
  input  logic                  in_Valid,
  output logic                  in_Ready,
  output logic [DATA_WIDTH-1:0] out_Data_0,
  output logic [DATA_WIDTH-1:0] out_Data_1,
  output logic [DATA_WIDTH-1:0] out_Data_2,
  output logic [DATA_WIDTH-1:0] out_Data_3,
  output logic                  out_Valid_0,
  output logic                  out_Valid_1,
  output logic                  out_Valid_2,
  output logic                  out_Valid_3,
  input  logic                  out_Ready_0,
  input  logic                  out_Ready_1,
  input  logic                  out_Ready_2,
  input  logic                  out_Ready_3,
  output logic [CNT_W-1:0]      drop_Count
);

  logic [NUM_DEST-1:0][DATA_WIDTH-1:0] slot_data;
  logic [NUM_DEST-1:0]                 slot_valid;
  logic [NUM_DEST-1:0]                 slot_ready;
  logic [NUM_DEST-1:0]                 slot_acc;
  logic [NUM_DEST-1:0]                 slot_load;
  logic                                xfer;
  logic [CNT_W-1:0]                    drop_q, drop_d;

  assign slot_ready = {out_Ready_3, out_Ready_2, out_Ready_1, out_Ready_0};

  // Ready follows only the addressed slot, never in_Valid
  assign in_Ready = slot_acc[selector];
  assign xfer     = in_Valid & in_Ready;

  // One-hot load: only the addressed slot takes the word
  always_comb begin
    slot_load = '0;
    if (xfer) slot_load[selector] = 1'b1;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_DEST; k++) begin : g_slot
      demux_4_bit_slot #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .load_i       (slot_load[k]),
        .data_i       (in_Data),
        .ready_i      (slot_ready[k]),
        .data_o       (slot_data[k]),
        .valid_o      (slot_valid[k]),
        .can_accept_o (slot_acc[k])
      );
    end
  endgenerate

  assign out_Data_0  = slot_data[0];
  assign out_Data_1  = slot_data[1];
  assign out_Data_2  = slot_data[2];
  assign out_Data_3  = slot_data[3];
  assign out_Valid_0 = slot_valid[0];
  assign out_Valid_1 = slot_valid[1];
  assign out_Valid_2 = slot_valid[2];
  assign out_Valid_3 = slot_valid[3];

  // Refused offer bumps the drop counter, sticking at its maximum
  always_comb begin
    drop_d = drop_q;
    if (in_Valid & ~in_Ready) drop_d = sat_inc(drop_q);
  end

  // Drop counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_Count = drop_q;

  // An offered word must carry a known destination
  a_sel_known: assert property (@(posedge clk) disable iff (rst)
                                in_Valid |-> !$isunknown(selector));

endmodule
